// File: rtl/rf_2r1w_clr_pkg.sv
// Shared types and helpers for the 2-read/1-write register file with
// hardware clear sweep.
package rf_pkg;

    // Clear-sequencer state: sweeping entries to zero, or normal operation
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    // True when an address maps onto an implemented entry
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/rf_2r1w_clr_clear_ctrl.sv
// Clear sequencer: after reset, sweeps a zero-write over every entry and
// holds busy until the last entry has been written.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;

    // Sweep FSM: reset parks at entry 0, each later edge clears one entry
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == LAST) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // The reset edge itself also zeroes entry 0, so the sweep starts clean
    assign o_clr_we   = !i_rst_n || (r_state == CLEAR);
    assign o_clr_addr = i_rst_n ? r_ptr : '0;
    assign o_busy     = r_busy;

endmodule

// File: rtl/rf_2r1w_clr.sv
// Register file, one write port and two independent registered read ports
// with write-to-read bypass. A hardware sweep zeroes all entries after reset.
// Optional macro RF_ZERO_REG_EN: entry 0 reads as zero and ignores writes.
module rf_2r1w_clr
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              W_E,
    input  logic [ADDR_W-1:0] W_A,
    input  logic [DATA_W-1:0] I,
    input  logic              R_E_A,
    input  logic [ADDR_W-1:0] R_A_A,
    output logic [DATA_W-1:0] RE_OUT_A,
    output logic              R_V_A,
    input  logic              R_E_B,
    input  logic [ADDR_W-1:0] R_A_B,
    output logic [DATA_W-1:0] RE_OUT_B,
    output logic              R_V_B,
    output logic              BUSY
);

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_out_a, r_out_b;
    logic              r_vld_a, r_vld_b;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;

    rf_clear_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // A user write lands only in RUN, in range, and not on a hardwired zero entry
    assign w_wr_ok = W_E && !w_busy
                  && in_range(32'(W_A), 32'(DEPTH))
                  && !(ZERO_REG && (W_A == '0));

    // Storage: the clear sweep has priority over user writes
    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[W_A] <= I;
        end
    end

    // Port A read mux: hardwired zero, then bypass, then array, else zero
    always_comb begin
        w_rd_a = '0;
        if (!(ZERO_REG && (R_A_A == '0))) begin
            if (w_wr_ok && (W_A == R_A_A)) begin
                w_rd_a = I;
            end else if (in_range(32'(R_A_A), 32'(DEPTH))) begin
                w_rd_a = r_mem[R_A_A];
            end
        end
    end

    // Port B read mux, identical to port A
    always_comb begin
        w_rd_b = '0;
        if (!(ZERO_REG && (R_A_B == '0))) begin
            if (w_wr_ok && (W_A == R_A_B)) begin
                w_rd_b = I;
            end else if (in_range(32'(R_A_B), 32'(DEPTH))) begin
                w_rd_b = r_mem[R_A_B];
            end
        end
    end

    // Port A output register: data holds when idle or busy, valid pulses per read
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_out_a <= '0;
            r_vld_a <= 1'b0;
        end else if (w_busy) begin
            r_vld_a <= 1'b0;
        end else if (R_E_A) begin
            r_out_a <= w_rd_a;
            r_vld_a <= 1'b1;
        end else begin
            r_vld_a <= 1'b0;
        end
    end

    // Port B output register, identical to port A
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_out_b <= '0;
            r_vld_b <= 1'b0;
        end else if (w_busy) begin
            r_vld_b <= 1'b0;
        end else if (R_E_B) begin
            r_out_b <= w_rd_b;
            r_vld_b <= 1'b1;
        end else begin
            r_vld_b <= 1'b0;
        end
    end

    assign RE_OUT_A = r_out_a;
    assign R_V_A    = r_vld_a;
    assign RE_OUT_B = r_out_b;
    assign R_V_B    = r_vld_b;
    assign BUSY     = w_busy;

endmodule
